// File: rtl/uart_tx_feeder.sv
// Byte FIFO feeding a UART transmitter: each queued byte is started with a
// one-cycle data-valid pulse, and the next pulse waits for one full Busy frame.
module uart_tx_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic [DATA_WIDTH-1:0] tx_p_data,
  output logic                  tx_data_valid,
  input  logic                  tx_busy
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] SEND       = 2'd1;
  localparam logic [1:0] WAIT_START = 2'd2;
  localparam logic [1:0] WAIT_DONE  = 2'd3;

  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic                  wr_accept;
  logic                  pop;

  assign full          = (count == DEPTH_CNT);
  assign empty         = (count == '0);
  assign tx_data_valid = (state == SEND);

  // The full decision uses the current count, so a pop in the same cycle
  // does not rescue a write issued against a full FIFO.
  assign wr_accept = wr_en && !full;
  assign pop       = (state == IDLE) && !empty && !tx_busy;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (!empty && !tx_busy) state_nxt = SEND;
      SEND:       state_nxt = WAIT_START;
      WAIT_START: if (tx_busy) state_nxt = WAIT_DONE;
      WAIT_DONE:  if (!tx_busy) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // NOTE: storage array has no reset; its contents are don't-care until
  // written, which lets it map onto plain RAM/register cells without reset.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state is assigned with non-blocking <= so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      state     <= IDLE;
      tx_p_data <= '0;
      overflow  <= 1'b0;
    end else begin
      state    <= state_nxt;
      overflow <= wr_en && full;
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        tx_p_data <= mem[rd_ptr];
      end
      case ({wr_accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: a queue-based reference model plus a UART Busy
// responder, compared against the DUT every cycle on the falling edge.
module tb_uart_tx_feeder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       full;
  logic       empty;
  logic       overflow;
  logic [7:0] tx_p_data;
  logic       tx_data_valid;
  logic       tx_busy;

  uart_tx_feeder #(.DATA_WIDTH(8), .FIFO_DEPTH(8), .ADDR_WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_en(wr_en),
    .full(full), .empty(empty), .overflow(overflow),
    .tx_p_data(tx_p_data), .tx_data_valid(tx_data_valid), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: FIFO contents as a queue, plus frame-handshake flags.
  logic [7:0] q[$];
  logic       m_valid, m_ovf, m_full, m_empty;
  logic [7:0] m_data;
  bit         ready;     // may start a new frame
  bit         saw_busy;  // Busy observed high since the last start
  // UART responder and output log.
  bit         tx_force, busy_rand, start_pend;
  int         busy_len, busy_cnt;
  logic [7:0] dut_out[$];

  function automatic void model_reset();
    q.delete();
    m_valid = 1'b0; m_data = 8'h00; m_ovf = 1'b0; m_full = 1'b0; m_empty = 1'b1;
    ready = 1'b1; saw_busy = 1'b0;
  endfunction

  function automatic string got_s();
    return $sformatf("v=%b d=%h o=%b f=%b e=%b", tx_data_valid, tx_p_data, overflow, full, empty);
  endfunction

  function automatic string want_s();
    return $sformatf("v=%b d=%h o=%b f=%b e=%b", m_valid, m_data, m_ovf, m_full, m_empty);
  endfunction

  function automatic bit idle_now();
    return q.size() == 0 && ready && !m_valid && busy_cnt == 0 && !start_pend && !tx_busy;
  endfunction

  // One clock: apply current inputs at the rising edge, update the model,
  // then drive Busy for the next edge. Comparisons are left to the caller.
  task automatic step();
    logic [7:0] wd;
    bit we, bz, accept;
    wd = wr_data; we = wr_en; bz = tx_busy;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    accept = we && (q.size() < 8);
    m_ovf  = we && (q.size() == 8);
    if (m_valid) m_valid = 1'b0;
    else if (ready) begin
      if (q.size() > 0 && !bz) begin
        m_data = q.pop_front(); m_valid = 1'b1; ready = 1'b0; saw_busy = 1'b0;
      end
    end
    else if (!saw_busy) saw_busy = bz;
    else if (!bz) ready = 1'b1;
    if (accept) q.push_back(wd);
    m_full  = (q.size() == 8);
    m_empty = (q.size() == 0);
    if (tx_data_valid === 1'b1) dut_out.push_back(tx_p_data);
    if (start_pend) begin
      busy_cnt   = busy_rand ? int'($urandom_range(12, 2)) : busy_len;
      start_pend = 1'b0;
    end
    if (m_valid) start_pend = 1'b1;
    tx_busy = tx_force || (busy_cnt > 0);
    if (busy_cnt > 0) busy_cnt--;
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; tx_busy = 1'b0;
    tx_force = 1'b0; busy_rand = 1'b0; busy_len = 4; busy_cnt = 0; start_pend = 1'b0;
    model_reset();
    #3;
    checks++;
    if ({tx_data_valid, tx_p_data, overflow, full, empty} !== {m_valid, m_data, m_ovf, m_full, m_empty}) begin
      errors++; $display("FAIL reset_state got %s want %s", got_s(), want_s());
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int pulses = 0;
    busy_rand = 1'b0; busy_len = 11;
    wr_data = 8'hA5; wr_en = 1'b1;
    step();
    checks++;
    if (tx_data_valid !== 1'b0 || empty !== 1'b0) begin
      errors++; $display("FAIL single_edge1 got v=%b e=%b want v=0 e=0", tx_data_valid, empty);
    end
    step();
    checks++;
    if (tx_data_valid !== 1'b1 || tx_p_data !== 8'hA5 || empty !== 1'b1) begin
      errors++; $display("FAIL single_edge2 got v=%b d=%h e=%b want v=1 d=a5 e=1", tx_data_valid, tx_p_data, empty);
    end
    for (int i = 0; i < 40 && !idle_now(); i++) begin
      step();
      if (tx_data_valid === 1'b1) pulses++;
      checks++;
      if ({tx_data_valid, tx_p_data, overflow, full, empty} !== {m_valid, m_data, m_ovf, m_full, m_empty}) begin
        errors++; $display("FAIL single cyc=%0d got %s want %s", cyc, got_s(), want_s());
      end
    end
    checks++;
    if (!idle_now() || pulses != 0) begin
      errors++; $display("FAIL single_frame_end got extra_pulses=%0d idle=%b want 0 1", pulses, idle_now());
    end
  endtask

  task automatic test_burst_overflow();
    dut_out.delete();
    tx_force = 1'b1; tx_busy = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      wr_data = 8'(i); wr_en = 1'b1;
      step();
      checks++;
      if ({tx_data_valid, tx_p_data, overflow, full, empty} !== {m_valid, m_data, m_ovf, m_full, m_empty}) begin
        errors++; $display("FAIL burst_fill cyc=%0d got %s want %s", cyc, got_s(), want_s());
      end
    end
    checks++;
    if (full !== 1'b1) begin
      errors++; $display("FAIL burst_full got %b want 1", full);
    end
    wr_data = 8'hFF; wr_en = 1'b1;
    step();
    checks++;
    if (overflow !== 1'b1 || full !== 1'b1) begin
      errors++; $display("FAIL burst_overflow got o=%b f=%b want o=1 f=1", overflow, full);
    end
    step();
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL burst_overflow_pulse got %b want 0", overflow);
    end
    tx_force = 1'b0; tx_busy = 1'b0; busy_rand = 1'b1;
    for (int i = 0; i < 400 && !idle_now(); i++) begin
      step();
      checks++;
      if ({tx_data_valid, tx_p_data, overflow, full, empty} !== {m_valid, m_data, m_ovf, m_full, m_empty}) begin
        errors++; $display("FAIL burst_drain cyc=%0d got %s want %s", cyc, got_s(), want_s());
      end
    end
    checks++;
    if (dut_out.size() != 8 || !idle_now()) begin
      errors++; $display("FAIL burst_count got %0d bytes want 8", dut_out.size());
    end
    for (int i = 0; i < 8 && i < dut_out.size(); i++) begin
      checks++;
      if (dut_out[i] !== 8'(i + 1)) begin
        errors++; $display("FAIL burst_order idx=%0d got %h want %h", i, dut_out[i], 8'(i + 1));
      end
    end
  endtask

  task automatic test_busy_hold();
    int pulses = 0;
    tx_force = 1'b1; tx_busy = 1'b1;
    wr_data = 8'($urandom); wr_en = 1'b1;
    for (int i = 0; i < 21; i++) begin
      step();
      if (tx_data_valid === 1'b1) pulses++;
      checks++;
      if ({tx_data_valid, tx_p_data, overflow, full, empty} !== {m_valid, m_data, m_ovf, m_full, m_empty}) begin
        errors++; $display("FAIL busy_hold cyc=%0d got %s want %s", cyc, got_s(), want_s());
      end
    end
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL busy_hold_pulses got %0d want 0", pulses);
    end
    tx_force = 1'b0; tx_busy = 1'b0;
    step();
    checks++;
    if (tx_data_valid !== 1'b1) begin
      errors++; $display("FAIL busy_release got v=%b want 1", tx_data_valid);
    end
    for (int i = 0; i < 60 && !idle_now(); i++) begin
      step();
      checks++;
      if ({tx_data_valid, tx_p_data, overflow, full, empty} !== {m_valid, m_data, m_ovf, m_full, m_empty}) begin
        errors++; $display("FAIL busy_drain cyc=%0d got %s want %s", cyc, got_s(), want_s());
      end
    end
  endtask

  task automatic test_full_pop();
    logic [7:0] sent[$];
    dut_out.delete();
    tx_force = 1'b1; tx_busy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_data = 8'($urandom_range(8'h76, 0)); wr_en = 1'b1;
      sent.push_back(wr_data);
      step();
    end
    checks++;
    if (full !== 1'b1) begin
      errors++; $display("FAIL fullpop_full got %b want 1", full);
    end
    tx_force = 1'b0; tx_busy = 1'b0;
    wr_data = 8'h77; wr_en = 1'b1;
    step();
    checks++;
    if ({tx_data_valid, tx_p_data, overflow, full} !== {1'b1, sent[0], 1'b1, 1'b0}) begin
      errors++; $display("FAIL fullpop_edge got v=%b d=%h o=%b f=%b want v=1 d=%h o=1 f=0",
                         tx_data_valid, tx_p_data, overflow, full, sent[0]);
    end
    for (int i = 0; i < 400 && !idle_now(); i++) begin
      step();
      checks++;
      if ({tx_data_valid, tx_p_data, overflow, full, empty} !== {m_valid, m_data, m_ovf, m_full, m_empty}) begin
        errors++; $display("FAIL fullpop_drain cyc=%0d got %s want %s", cyc, got_s(), want_s());
      end
    end
    checks++;
    if (dut_out.size() != 8 || dut_out != sent) begin
      errors++; $display("FAIL fullpop_stream got %0d bytes want 8 in order, no 77", dut_out.size());
    end
  endtask

  task automatic test_wrap();
    logic [7:0] sent[$];
    dut_out.delete();
    busy_rand = 1'b1;
    for (int n = 0; n < 12; n++) begin
      for (int g = $urandom_range(10, 4); g > 0; g--) begin
        step();
        checks++;
        if ({tx_data_valid, tx_p_data, overflow, full, empty} !== {m_valid, m_data, m_ovf, m_full, m_empty}) begin
          errors++; $display("FAIL wrap cyc=%0d got %s want %s", cyc, got_s(), want_s());
        end
      end
      wr_data = 8'($urandom); wr_en = 1'b1;
      sent.push_back(wr_data);
    end
    for (int i = 0; i < 600 && !idle_now(); i++) begin
      step();
      checks++;
      if ({tx_data_valid, tx_p_data, overflow, full, empty} !== {m_valid, m_data, m_ovf, m_full, m_empty}) begin
        errors++; $display("FAIL wrap_drain cyc=%0d got %s want %s", cyc, got_s(), want_s());
      end
    end
    checks++;
    if (dut_out != sent || !idle_now()) begin
      errors++; $display("FAIL wrap_stream got %0d bytes want %0d in order", dut_out.size(), sent.size());
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    busy_rand = 1'b0; busy_len = 30;
    for (int i = 0; i < 4; i++) begin
      wr_data = 8'($urandom); wr_en = 1'b1;
      step();
    end
    for (int i = 0; i < 10 && !(saw_busy && !ready && !m_valid); i++) step();
    checks++;
    if (!(saw_busy && !ready) || empty !== 1'b0 || tx_busy !== 1'b1) begin
      errors++; $display("FAIL resetmid_setup got e=%b busy=%b want e=0 busy=1", empty, tx_busy);
    end
    #2 rst_n = 1'b0;
    model_reset();
    busy_cnt = 0; start_pend = 1'b0; tx_force = 1'b0;
    #1;
    checks++;
    if ({tx_data_valid, tx_p_data, overflow, full, empty} !== {m_valid, m_data, m_ovf, m_full, m_empty}) begin
      errors++; $display("FAIL resetmid_async got %s want %s", got_s(), want_s());
    end
    tx_busy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tx_data_valid === 1'b1) pulses++;
      checks++;
      if ({tx_data_valid, tx_p_data, overflow, full, empty} !== {m_valid, m_data, m_ovf, m_full, m_empty}) begin
        errors++; $display("FAIL resetmid_quiet cyc=%0d got %s want %s", cyc, got_s(), want_s());
      end
    end
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL resetmid_pulses got %0d want 0", pulses);
    end
    wr_data = 8'h3C; wr_en = 1'b1;
    step();
    step();
    checks++;
    if (tx_data_valid !== 1'b1 || tx_p_data !== 8'h3C) begin
      errors++; $display("FAIL resetmid_newwrite got v=%b d=%h want v=1 d=3c", tx_data_valid, tx_p_data);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst_overflow();
    test_busy_hold();
    test_full_pop();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout at cyc=%0d want completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
